// File: rtl/im_arb_ctrl_pkg.sv
// Shared definitions for the instruction-memory port controller: state encoding,
// default sizing and the debug starvation-counter update rule.
package im_arb_ctrl_pkg;

  localparam int IM_AW       = 10;
  localparam int IM_MAX_WAIT = 4;
  localparam int IM_WAIT_W   = 4;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } im_state_e;

  // Next value of the debug wait counter: clears unless debug was denied, saturates at lim.
  function automatic logic [IM_WAIT_W-1:0] wait_next(
    input logic [IM_WAIT_W-1:0] cnt,
    input logic [IM_WAIT_W-1:0] lim,
    input logic                 denied
  );
    if (!denied) begin
      return '0;
    end else if (cnt >= lim) begin
      return lim;
    end else begin
      return cnt + 1'b1;
    end
  endfunction

endpackage

// File: rtl/im_arb_ctrl_rr_guard.sv
// im_rr_guard: fetch-priority grant select with a bounded-wait guard for the debug port.
// Debug requester and wait counter exist only when IM_DBG_PORT_EN is defined.
module im_rr_guard
  import im_arb_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = IM_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic dbg_req,
  output logic if_gnt,
  output logic dbg_gnt
);

`ifdef IM_DBG_PORT_EN
  localparam logic [IM_WAIT_W-1:0] WAIT_LIM = IM_WAIT_W'(MAX_WAIT);

  logic [IM_WAIT_W-1:0] wait_cnt;

  // A debug requester denied WAIT_LIM times in a row overrides fetch priority once.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (en) begin
      if (dbg_req && (wait_cnt == WAIT_LIM)) begin
        dbg_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_next(wait_cnt, WAIT_LIM, dbg_req && !dbg_gnt);
    end
  end
`else
  logic unused_guard;

  assign if_gnt       = en & if_req;
  assign dbg_gnt      = 1'b0;
  assign unused_guard = ^{clk, rst, dbg_req};
`endif

endmodule

// File: rtl/im_arb_ctrl.sv
// im_arb_ctrl: owns the single instruction-memory port; boot-loads it, then arbitrates
// fetch and debug reads with registered read data. Debug port enabled by IM_DBG_PORT_EN.
module im_arb_ctrl
  import im_arb_ctrl_pkg::*;
#(
  parameter int AW       = IM_AW,
  parameter int MAX_WAIT = IM_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] im_addr,
  output logic          im_we,
  output logic [31:0]   im_wdata,
  input  logic [31:0]   im_rdata,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          boot_done,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output im_state_e     fsm_state
);

  // Handshakes: a loader word transfers on a cycle with ld_valid && ld_ready; a read
  // request transfers on a cycle with req && gnt, and its data arrives with rvalid on
  // the following cycle. Requesters hold req (and addr) until granted.

  im_state_e     state;
  logic [AW-1:0] ld_ptr;
  logic          run;
  logic          ld_acc;
  logic          ld_end;
  logic          if_gnt_c;
  logic          dbg_gnt_c;

  assign run       = (state == ST_RUN);
  assign boot_done = run;
  assign fsm_state = state;
  assign ld_ready  = (state == ST_LOAD) && !rst;
  assign ld_acc    = ld_ready && ld_valid;
  assign ld_end    = ld_last || (ld_ptr == {AW{1'b1}});

  im_rr_guard #(
    .MAX_WAIT (MAX_WAIT)
  ) u_guard (
    .clk     (clk),
    .rst     (rst),
    .en      (run && !rst),
    .if_req  (if_req),
    .dbg_req (dbg_req),
    .if_gnt  (if_gnt_c),
    .dbg_gnt (dbg_gnt_c)
  );

  assign if_gnt  = if_gnt_c;
  assign dbg_gnt = dbg_gnt_c;

  assign im_we    = ld_acc;
  assign im_wdata = ld_acc ? ld_data : 32'h0;

  always_comb begin
    im_addr = '0;
    if (!run) begin
      im_addr = ld_ptr;
    end else if (if_gnt_c) begin
      im_addr = if_addr;
    end else if (dbg_gnt_c) begin
      im_addr = dbg_addr;
    end
  end

  // The load pointer stops at the last word instead of wrapping to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_LOAD;
      ld_ptr <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            if (ld_end) begin
              state <= ST_RUN;
            end else begin
              ld_ptr <= ld_ptr + 1'b1;
            end
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
    end else begin
      if_rvalid <= if_gnt_c;
      if (if_gnt_c) begin
        if_rdata <= im_rdata;
      end
    end
  end

`ifdef IM_DBG_PORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= 32'h0;
    end else begin
      dbg_rvalid <= dbg_gnt_c;
      if (dbg_gnt_c) begin
        dbg_rdata <= im_rdata;
      end
    end
  end
`else
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = 32'h0;
`endif

endmodule

// File: tb/tb_im_arb_ctrl.sv
// Self-checking bench for im_arb_ctrl: memory model, randomized loader and requester
// traffic, and a spec-level arbitration/scoreboard model. Honours IM_DBG_PORT_EN.
module tb_im_arb_ctrl;
  import im_arb_ctrl_pkg::*;

  localparam int AW       = 10;
  localparam int DEPTH    = 1024;
  localparam int MAX_WAIT = 4;
`ifdef IM_DBG_PORT_EN
  localparam bit DBG_ON = 1'b1;
`else
  localparam bit DBG_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] im_addr;
  logic          im_we;
  logic [31:0]   im_wdata;
  logic [31:0]   im_rdata;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = 32'h0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          boot_done;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;
  im_state_e     fsm_state;

  im_arb_ctrl #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata), .im_rdata(im_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .boot_done(boot_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .fsm_state(fsm_state)
  );

  // memory the DUT drives
  logic [31:0] mem [DEPTH];
  int          wr0_count = 0;
  always @(posedge clk) begin
    if (im_we) begin
      mem[im_addr] <= im_wdata;
      if (im_addr == '0) wr0_count <= wr0_count + 1;
    end
  end
  assign im_rdata = mem[im_addr];

  // reference model and scoreboard
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dbg_q[$];
  int          denied;
  bit          prev_ig, prev_dg;
  logic [31:0] last_if_data, last_dbg_data;
  int          n_if_gnt, n_dbg_gnt, n_if_rv, n_dbg_rv, n_if_req;
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    denied        = 0;
    prev_ig       = 1'b0;
    prev_dg       = 1'b0;
    last_if_data  = 32'h0;
    last_dbg_data = 32'h0;
    exp_if_q.delete();
    exp_dbg_q.delete();
  endtask

  task automatic clear_counts();
    n_if_gnt = 0; n_dbg_gnt = 0; n_if_rv = 0; n_dbg_rv = 0; n_if_req = 0;
  endtask

  // driver tasks
  task automatic do_reset(input int n);
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic load_words(input int n, input bit rand_data, input logic [31:0] base,
                            input bit with_last, input bit gaps);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          ld_valid = 1'b0;
          @(negedge clk);
          checks++;
          if ({ld_ready, im_we, boot_done} !== 3'b100) begin
            errors++;
            $display("FAIL load_gap: got ready/we/done=%b want 100", {ld_ready, im_we, boot_done});
          end
          @(posedge clk); #1;
        end
      end
      d = rand_data ? $urandom : base + 32'(i);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = with_last && (i == n - 1);
      @(negedge clk);
      checks++;
      if ({ld_ready, im_we, boot_done, if_gnt, dbg_gnt, if_rvalid, dbg_rvalid} !== 7'b1100000) begin
        errors++;
        $display("FAIL load_ctrl word %0d: got rdy/we/done/ig/dg/irv/drv=%b want 1100000", i,
                 {ld_ready, im_we, boot_done, if_gnt, dbg_gnt, if_rvalid, dbg_rvalid});
      end
      checks++;
      if (im_addr !== AW'(i) || im_wdata !== d) begin
        errors++;
        $display("FAIL load_write word %0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, im_addr, im_wdata, i, d);
      end
      ref_mem[i] = d;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // One RUN-phase cycle per iteration; mode picks the request pattern:
  // 0 random, 1 both held, 2 fetch at fixaddr, 3 debug held + random fetch, 4 idle, 5 fetch held.
  task automatic run_traffic(input int n, input int mode, input int fixaddr, input int amax);
    bit            ir, dr, eig, edg;
    logic [AW-1:0] ia, da, ea;
    logic [31:0]   exp_d;
    for (int c = 0; c < n; c++) begin
      ia = AW'($urandom_range(0, amax));
      da = AW'($urandom_range(0, amax));
      ir = 1'b0; dr = 1'b0;
      case (mode)
        0: begin ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); end
        1: begin ir = 1'b1; dr = 1'b1; end
        2: begin ir = 1'b1; ia = AW'(fixaddr); end
        3: begin ir = 1'($urandom_range(0, 1)); dr = 1'b1; end
        5: ir = 1'b1;
        default: ;
      endcase
      if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
      ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));

      // reference: fetch first unless debug has already been turned away MAX_WAIT times running
      eig = 1'b0; edg = 1'b0;
      if (DBG_ON && dr && denied == MAX_WAIT) edg = 1'b1;
      else if (ir)                            eig = 1'b1;
      else if (DBG_ON && dr)                  edg = 1'b1;
      if (dr && !edg) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
      else            denied = 0;
      ea = eig ? ia : (edg ? da : '0);
      n_if_req += int'(ir);

      @(negedge clk);
      n_if_gnt += int'(if_gnt); n_dbg_gnt += int'(dbg_gnt);
      n_if_rv  += int'(if_rvalid); n_dbg_rv += int'(dbg_rvalid);
      checks++;
      if ({if_gnt, dbg_gnt} !== {eig, edg}) begin
        errors++;
        $display("FAIL run_gnt: got if/dbg=%b want %b", {if_gnt, dbg_gnt}, {eig, edg});
      end
      checks++;
      if (im_addr !== ea) begin
        errors++;
        $display("FAIL run_addr: got %0d want %0d", im_addr, ea);
      end
      checks++;
      if ({im_we, ld_ready, boot_done} !== 3'b001) begin
        errors++;
        $display("FAIL run_ctrl: got we/rdy/done=%b want 001", {im_we, ld_ready, boot_done});
      end
      checks++;
      if ({if_rvalid, dbg_rvalid} !== {prev_ig, prev_dg}) begin
        errors++;
        $display("FAIL run_rvalid: got if/dbg=%b want %b", {if_rvalid, dbg_rvalid}, {prev_ig, prev_dg});
      end
      exp_d = prev_ig ? exp_if_q.pop_front() : last_if_data;
      checks++;
      if (if_rdata !== exp_d) begin
        errors++;
        $display("FAIL if_rdata: got %h want %h", if_rdata, exp_d);
      end
      last_if_data = exp_d;
      exp_d = prev_dg ? exp_dbg_q.pop_front() : last_dbg_data;
      checks++;
      if (dbg_rdata !== exp_d) begin
        errors++;
        $display("FAIL dbg_rdata: got %h want %h", dbg_rdata, exp_d);
      end
      last_dbg_data = exp_d;
      if (eig) exp_if_q.push_back(ref_mem[ia]);
      if (edg) exp_dbg_q.push_back(ref_mem[da]);
      prev_ig = eig; prev_dg = edg;
      @(posedge clk); #1;
    end
    if_req = 1'b0; dbg_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b1; ld_data = $urandom; if_req = 1'b1; if_addr = 10'd1;
    dbg_req = 1'b1; dbg_addr = 10'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ld_ready, boot_done, if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, im_we} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {ld_ready, boot_done, if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, im_we});
    end
    checks++;
    if ({if_rdata, dbg_rdata, im_wdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want 0", if_rdata, dbg_rdata, im_wdata);
    end
    checks++;
    if (fsm_state !== ST_LOAD) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_LOAD);
    end
    ld_valid = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({ld_ready, boot_done, if_gnt, im_we} !== 4'b1000 || im_addr !== '0) begin
      errors++;
      $display("FAIL post_reset: got rdy/done/ig/we=%b addr=%0d want 1000 addr=0",
               {ld_ready, boot_done, if_gnt, im_we}, im_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boot_load();
    if_req = 1'b1; if_addr = 10'd2; dbg_req = 1'b0;
    load_words(5, 1'b0, 32'h1000_0000, 1'b1, 1'b0);
    run_traffic(1, 2, 2, 4);
    run_traffic(1, 2, 3, 4);
    run_traffic(1, 4, 0, 4);
    checks++;
    if (if_rdata !== 32'h1000_0003) begin
      errors++;
      $display("FAIL boot_fetch3: got %h want 10000003", if_rdata);
    end
  endtask

  task automatic test_starvation();
    clear_counts();
    run_traffic(20, 1, 0, 4);
    run_traffic(1, 4, 0, 4);
    checks++;
`ifdef IM_DBG_PORT_EN
    if (n_if_gnt != 16 || n_dbg_gnt != 4) begin
`else
    if (n_if_gnt != 20 || n_dbg_gnt != 0) begin
`endif
      errors++;
      $display("FAIL starve_split: got if=%0d dbg=%0d grants over 20 cycles", n_if_gnt, n_dbg_gnt);
    end
  endtask

  task automatic test_full_load();
    int w0;
    do_reset(2);
    w0 = wr0_count;
    load_words(DEPTH, 1'b1, 32'h0, 1'b0, 1'b1);
    run_traffic(10, 4, 0, DEPTH - 1);
    checks++;
    if (wr0_count != w0 + 1) begin
      errors++;
      $display("FAIL full_no_wrap: got %0d writes to word 0 want 1", wr0_count - w0);
    end
  endtask

  task automatic test_random_traffic();
    run_traffic(300, 0, 0, DEPTH - 1);
    run_traffic(1, 4, 0, DEPTH - 1);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    run_traffic(12, 5, 0, DEPTH - 1);
    run_traffic(1, 4, 0, DEPTH - 1);
    checks++;
    if (n_if_gnt != 12 || n_if_rv != 12) begin
      errors++;
      $display("FAIL b2b_count: got gnt=%0d rvalid=%0d want 12 12", n_if_gnt, n_if_rv);
    end
  endtask

  task automatic test_dbg_held();
    clear_counts();
    run_traffic(30, 3, 0, DEPTH - 1);
    run_traffic(1, 4, 0, DEPTH - 1);
    checks++;
`ifdef IM_DBG_PORT_EN
    if (n_if_gnt + n_dbg_gnt != 30 || n_dbg_rv != n_dbg_gnt) begin
`else
    if (n_dbg_gnt != 0 || n_dbg_rv != 0 || n_if_gnt != n_if_req) begin
`endif
      errors++;
      $display("FAIL dbg_held: got if=%0d dbg=%0d dbg_rv=%0d if_req=%0d",
               n_if_gnt, n_dbg_gnt, n_dbg_rv, n_if_req);
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 10'd3; dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_gnt: got %b want 1", if_gnt);
    end
    rst = 1'b1;
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, dbg_rvalid, boot_done} !== 3'b000 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_rvalid_suppress: got rv/drv/done=%b rdata=%h want 000 0",
               {if_rvalid, dbg_rvalid, boot_done}, if_rdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    load_words(3, 1'b0, 32'h2000_0000, 1'b0, 1'b0);
    do_reset(1);
    load_words(2, 1'b0, 32'h3000_0000, 1'b1, 1'b0);
    run_traffic(1, 2, 0, 2);
    run_traffic(1, 2, 1, 2);
    run_traffic(1, 2, 2, 2);
    run_traffic(1, 4, 0, 2);
    checks++;
    if (if_rdata !== 32'h2000_0002) begin
      errors++;
      $display("FAIL mid_mem_kept: got %h want 20000002", if_rdata);
    end
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_boot_load();
    test_starvation();
    test_full_load();
    test_random_traffic();
    test_back_to_back();
    test_dbg_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
